// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Optional checksum trailer is enabled by defining INST_LOADER_CHECKSUM_EN.
package inst_mem_loader_pkg;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;

`ifdef INST_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam state_e S_AFTER_DATA = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam state_e S_AFTER_DATA = S_DONE;
`endif

    // Byte address of word number idx; wraps modulo 2^32 by construction.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [31:0] idx);
        return base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Byte-stream input, instruction-memory write port and boot status of the loader.
interface inst_mem_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
    );

endinterface

// File: rtl/inst_mem_loader_byte_word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_valid_o pulses while the
// 4th byte of a word is being accepted, with the complete word on word_o.
module inst_mem_loader_byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] shift_q,    shift_d;

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        if (byte_valid_i) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q != 2'd3) begin
                shift_d[int'(byte_idx_q) * 8 +: 8] = byte_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_q <= 2'd0;
            shift_q    <= 24'd0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
        end
    end

    assign word_valid_o = byte_valid_i && (byte_idx_q == 2'd3);
    assign word_o       = {byte_i, shift_q};

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: length header + N little-endian words written to instruction memory;
// holds the core in reset until done. INST_LOADER_CHECKSUM_EN adds a sum trailer.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 65536,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_mem_loader_if.slave bus
);

    state_e      state_q,     state_d;
    logic [31:0] word_cnt_q,  word_cnt_d;
    logic [31:0] n_q,         n_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
    logic [31:0] sum_q,       sum_d;
`endif

    logic        in_ready;
    logic        accept;
    logic        word_valid;
    logic [31:0] word;

    assign accept = bus.in_valid && in_ready;

    inst_mem_loader_byte_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid_i (accept),
        .byte_i       (bus.in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        n_d         = n_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef INST_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        unique case (state_q)
            S_LEN: begin
                if (word_valid) begin
                    n_d = word;
                    if (word > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else if (word == 32'd0) begin
                        state_d = S_AFTER_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = word;
                    mem_addr_d  = word_byte_addr(BASE_ADDR, word_cnt_q);
                    word_cnt_d  = word_cnt_q + 32'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + word;
`endif
                    if (word_cnt_q + 32'd1 == n_q) begin
                        state_d = S_AFTER_DATA;
                    end
                end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (word_valid) begin
                    state_d = (word == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_LEN;
            word_cnt_q  <= 32'd0;
            n_q         <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'd0;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            n_q         <= n_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    // Status depends on state only, so in_ready never looks at in_valid.
    always_comb begin
        in_ready       = 1'b0;
        bus.cpu_hold   = 1'b1;
        bus.load_done  = 1'b0;
        bus.load_error = 1'b0;
        unique case (state_q)
            S_LEN, S_DATA: in_ready = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            S_CSUM:        in_ready = 1'b1;
`endif
            S_DONE: begin
                bus.cpu_hold  = 1'b0;
                bus.load_done = 1'b1;
            end
            S_ERR:   bus.load_error = 1'b1;
            default: bus.load_error = 1'b1;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
